// File: rtl/gol_engine.sv
// gol_engine: Game of Life core on the pixel clock. Double-buffered GRID_W x GRID_H
// cell array, one cell evaluated per clock, buffer swap deferred to vertical blanking.
// Also maps VGA x/y to a registered cell colour.
module gol_engine #(
  parameter int          GRID_W      = 40,
  parameter int          GRID_H      = 30,
  parameter int          CELL_SHIFT  = 4,
  parameter int          V_ACTIVE    = 480,
  parameter int          TICK_CYCLES = 6250000,
  parameter int          WRAP        = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [11:0] ALIVE_RGB   = 12'hFFF,
  parameter logic [11:0] DEAD_RGB    = 12'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  key,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        busy,
  output logic [15:0] gen_count
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int CW    = 7;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NCELL - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(GRID_W - 1);
  localparam logic [31:0]   TICK_LAST = 32'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, SWAP_WAIT, SEED} state_t;

  state_t            state_q, state_d;
  logic [NCELL-1:0]  cur_q, cur_d, nxt_q, nxt_d;
  logic [3:0]        key_meta_q, key_meta_d, key_sync_q, key_sync_d, key_prev_q, key_prev_d;
  logic              running_q, running_d, pend_q, pend_d;
  logic [31:0]       tick_cnt_q, tick_cnt_d;
  logic [15:0]       lfsr_q, lfsr_d, gen_q, gen_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     col_q, col_d, row_q, row_d;
  logic [11:0]       rgb_q, rgb_d;

  logic [3:0]        key_edge;
  logic              tick;
  logic [3:0]        nbr_cnt;
  logic              next_cell;
  logic [9:0]        pcol, prow;
  logic [IW-1:0]     pix_idx;
  logic              pix_in;

  assign key_edge = key_sync_q & ~key_prev_q;
  assign tick     = running_q && (tick_cnt_q == TICK_LAST);

  // Count live neighbours of the cell under the scan pointer (toroidal or dead edge).
  always_comb begin
    int   rr, cc;
    logic in_rng;
    rr      = 0;
    cc      = 0;
    in_rng  = 1'b0;
    nbr_cnt = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr     = int'(row_q) + dr;
        cc     = int'(col_q) + dc;
        in_rng = (rr >= 0) && (rr < GRID_H) && (cc >= 0) && (cc < GRID_W);
        if (WRAP != 0) begin
          if (rr < 0) rr = GRID_H - 1;
          else if (rr >= GRID_H) rr = 0;
          if (cc < 0) cc = GRID_W - 1;
          else if (cc >= GRID_W) cc = 0;
          in_rng = 1'b1;
        end
        if (!(dr == 0 && dc == 0) && in_rng)
          nbr_cnt = nbr_cnt + {3'b000, cur_q[IW'(rr * GRID_W + cc)]};
      end
    end
    next_cell = (nbr_cnt == 4'd3) | (cur_q[idx_q] & (nbr_cnt == 4'd2));
  end

  // Pixel lookup: blank outside the visible area and outside the grid.
  always_comb begin
    pcol    = x >> CELL_SHIFT;
    prow    = y >> CELL_SHIFT;
    pix_in  = video_on && (int'(pcol) < GRID_W) && (int'(prow) < GRID_H);
    pix_idx = IW'(int'(prow) * GRID_W + int'(pcol));
    rgb_d   = 12'h000;
    if (pix_in) rgb_d = cur_q[pix_idx] ? ALIVE_RGB : DEAD_RGB;
  end

  // Key sync, run/tick bookkeeping and the IDLE/UPDATE/SWAP_WAIT/SEED sequencer.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    lfsr_d     = lfsr_q;
    gen_d      = gen_q;
    idx_d      = idx_q;
    col_d      = col_q;
    row_d      = row_q;
    key_meta_d = key;
    key_sync_d = key_meta_q;
    key_prev_d = key_sync_q;
    running_d  = running_q ^ key_edge[0];
    tick_cnt_d = (!running_q || tick) ? 32'd0 : tick_cnt_q + 32'd1;
    // A tick not consumed this cycle is remembered (one deep).
    pend_d     = pend_q | tick;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        col_d = '0;
        row_d = '0;
        if (key_edge[2]) begin
          cur_d = '0;
          nxt_d = '0;
          gen_d = 16'd0;
        end else if (key_edge[3]) begin
          state_d = SEED;
        end else if (key_edge[1] && !running_q) begin
          state_d = UPDATE;
        end else if (tick || pend_q) begin
          state_d = UPDATE;
          pend_d  = 1'b0;
        end
      end
      UPDATE, SEED: begin
        if (state_q == UPDATE) begin
          nxt_d[idx_q] = next_cell;
        end else begin
          cur_d[idx_q] = lfsr_q[0];
          lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
        if (idx_q == LAST_IDX) begin
          if (state_q == UPDATE) begin
            state_d = SWAP_WAIT;
          end else begin
            state_d = IDLE;
            gen_d   = 16'd0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      SWAP_WAIT: begin
        // Swap only in vertical blanking so a frame never shows two generations.
        if (!video_on && (int'(y) >= V_ACTIVE)) begin
          cur_d   = nxt_q;
          gen_d   = gen_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pausing forgets any queued generation and restarts the interval.
    if (!running_d) begin
      tick_cnt_d = 32'd0;
      pend_d     = 1'b0;
    end
  end

  // State register; reset returns everything, including both buffers, to dead/idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      nxt_q      <= '0;
      key_meta_q <= 4'd0;
      key_sync_q <= 4'd0;
      key_prev_q <= 4'd0;
      running_q  <= 1'b0;
      pend_q     <= 1'b0;
      tick_cnt_q <= 32'd0;
      lfsr_q     <= LFSR_SEED;
      gen_q      <= 16'd0;
      idx_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rgb_q      <= 12'h000;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      key_prev_q <= key_prev_d;
      running_q  <= running_d;
      pend_q     <= pend_d;
      tick_cnt_q <= tick_cnt_d;
      lfsr_q     <= lfsr_d;
      gen_q      <= gen_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rgb_q      <= rgb_d;
    end
  end

  assign {r, g, b}  = rgb_q;
  assign busy       = (state_q != IDLE);
  assign gen_count  = gen_q;

endmodule

// File: tb/tb_gol_engine.sv
// Bench for gol_engine on a 10x8 toroidal grid. Cell contents are observed through
// the pixel port only; expected grids come from a bench-side LFSR and Life model.
module tb_gol_engine;
  localparam int          W     = 10;
  localparam int          H     = 8;
  localparam int          N     = W * H;
  localparam int          TICK  = 41;
  localparam logic [11:0] ALIVE = 12'hFA5;
  localparam logic [11:0] DEAD  = 12'h246;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  key;
  logic [9:0]  x, y;
  logic        video_on;
  logic [3:0]  r, g, b;
  logic        busy;
  logic [15:0] gen_count;

  gol_engine #(
    .GRID_W(W), .GRID_H(H), .CELL_SHIFT(4), .V_ACTIVE(480), .TICK_CYCLES(TICK),
    .WRAP(1), .LFSR_SEED(SEED), .ALIVE_RGB(ALIVE), .DEAD_RGB(DEAD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key(key), .x(x), .y(y), .video_on(video_on),
    .r(r), .g(g), .b(b), .busy(busy), .gen_count(gen_count)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic [11:0] exp;
  } pix_vec_t;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [N-1:0] m_grid;
  logic [15:0]  m_lfsr;
  logic [15:0]  m_gen;
  pix_vec_t     vecs[13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic blank();
    video_on = 1'b0;
    x        = 10'd0;
    y        = 10'd490;
  endtask

  task automatic pulse(input logic [3:0] kmask);
    key = kmask;
    repeat (4) cyc();
    key = 4'd0;
  endtask

  // Press keys, then count busy cycles until the operation finishes.
  task automatic press(input logic [3:0] kmask, input int budget, output int bcnt);
    bcnt = 0;
    key  = kmask;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (i == 3) key = 4'd0;
      if (busy) bcnt++;
      else if (bcnt > 0) break;
    end
    key = 4'd0;
    check("idle after op", busy, 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      cyc();
    end
    check("idle reached", busy, 0);
  endtask

  task automatic wait_gen(input int budget, output int cycles);
    logic [15:0] g0;
    g0     = gen_count;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      cycles++;
      if (gen_count != g0) break;
    end
    check("generation advanced", gen_count != g0, 1);
  endtask

  task automatic read_grid(input logic keep_vis, output logic [N-1:0] got);
    got = '0;
    for (int i = 0; i < N; i++) begin
      x        = 10'((i % W) * 16 + 7);
      y        = 10'((i / W) * 16 + 9);
      video_on = 1'b1;
      cyc();
      got[7'(i)] = ({r, g, b} == ALIVE);
    end
    if (keep_vis) begin
      x = 10'd0;
      y = 10'd100;
    end else begin
      blank();
    end
  endtask

  task automatic check_grid(input string name);
    logic [N-1:0] got;
    read_grid(1'b0, got);
    check(name, got, m_grid);
  endtask

  task automatic model_seed();
    for (int i = 0; i < N; i++) begin
      m_grid[7'(i)] = m_lfsr[0];
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
    m_gen = 16'd0;
  endtask

  task automatic model_step();
    logic [N-1:0] nx;
    int cnt;
    nx = '0;
    for (int rr = 0; rr < H; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              cnt += int'(m_grid[7'(((rr + dr + H) % H) * W + ((cc + dc + W) % W))]);
        nx[7'(rr * W + cc)] = (cnt == 3) || (m_grid[7'(rr * W + cc)] && cnt == 2);
      end
    end
    m_grid = nx;
    m_gen  = m_gen + 16'd1;
  endtask

  initial begin
    int bc, c0, c1, c2;
    logic [N-1:0] got;

    // Pixel vectors against the LFSR_SEED pattern: cell i holds bit i of 16'hACE1.
    vecs[0]  = '{10'd0,   10'd0,   1'b1, ALIVE};   // cell 0
    vecs[1]  = '{10'd15,  10'd15,  1'b1, ALIVE};   // still cell 0
    vecs[2]  = '{10'd16,  10'd0,   1'b1, DEAD};    // cell 1
    vecs[3]  = '{10'd79,  10'd0,   1'b1, DEAD};    // cell 4
    vecs[4]  = '{10'd80,  10'd0,   1'b1, ALIVE};   // cell 5
    vecs[5]  = '{10'd159, 10'd0,   1'b1, DEAD};    // cell 9
    vecs[6]  = '{10'd160, 10'd0,   1'b1, 12'h000}; // col 10 outside grid
    vecs[7]  = '{10'd0,   10'd16,  1'b1, ALIVE};   // cell 10
    vecs[8]  = '{10'd32,  10'd16,  1'b1, DEAD};    // cell 12
    vecs[9]  = '{10'd48,  10'd16,  1'b1, ALIVE};   // cell 13
    vecs[10] = '{10'd0,   10'd0,   1'b0, 12'h000}; // video off
    vecs[11] = '{10'd0,   10'd128, 1'b1, 12'h000}; // row 8 outside grid
    vecs[12] = '{10'd639, 10'd479, 1'b1, 12'h000};

    reset_n = 1'b0;
    key     = 4'd0;
    blank();
    repeat (3) cyc();
    check("reset rgb", {r, g, b}, 0);
    check("reset busy", busy, 0);
    check("reset gen", gen_count, 0);
    reset_n = 1'b1;
    cyc();
    m_lfsr = SEED;
    m_grid = '0;
    m_gen  = 16'd0;
    check_grid("reset grid");

    // Seed: busy exactly one cycle per cell.
    press(4'b1000, 3000, bc);
    check("seed busy cycles", bc, N);
    model_seed();
    check("seed gen", gen_count, 0);
    check_grid("seed grid");

    foreach (vecs[i]) begin
      x        = vecs[i].x;
      y        = vecs[i].y;
      video_on = vecs[i].von;
      cyc();
      check($sformatf("pixel vec %0d", i), {r, g, b}, vecs[i].exp);
    end
    blank();

    // Step in blanking: N update cycles plus one swap cycle.
    press(4'b0010, 3000, bc);
    check("step busy cycles", bc, N + 1);
    model_step();
    check("step gen", gen_count, m_gen);
    check_grid("step grid");

    // Swap held off while visible and during horizontal blanking.
    video_on = 1'b1;
    y        = 10'd100;
    pulse(4'b0010);
    repeat (N + 20) cyc();
    check("swap wait busy", busy, 1);
    check("swap wait gen", gen_count, m_gen);
    read_grid(1'b1, got);
    check("no tearing grid", got, m_grid);
    video_on = 1'b0;
    repeat (5) cyc();
    check("hblank no swap", busy, 1);
    y = 10'd490;
    repeat (2) cyc();
    check("vblank swap busy", busy, 0);
    model_step();
    check("vblank swap gen", gen_count, m_gen);
    check_grid("swapped grid");

    // Clear and seed during UPDATE are ignored.
    pulse(4'b0010);
    repeat (2) cyc();
    pulse(4'b1100);
    wait_idle(300);
    model_step();
    check("ignored keys gen", gen_count, m_gen);
    check_grid("ignored keys grid");

    // Clear + step + seed together: only clear acts.
    press(4'b1110, 10, bc);
    check("clear busy cycles", bc, 0);
    check("clear gen", gen_count, 0);
    m_grid = '0;
    m_gen  = 16'd0;
    check_grid("clear grid");

    // Reseed continues the LFSR sequence.
    press(4'b1000, 3000, bc);
    check("reseed busy cycles", bc, N);
    model_seed();
    check_grid("reseed grid");

    // Running: one generation per update back to back (tick period shorter than an update).
    pulse(4'b0001);
    wait_gen(400, c0);
    model_step();
    check("run gen 1", gen_count, m_gen);
    wait_gen(400, c1);
    model_step();
    check("run period 1", c1, N + 2);
    wait_gen(400, c2);
    model_step();
    check("run period 2", c2, N + 2);
    check("run gen 3", gen_count, m_gen);
    // Pause mid-update after a pending tick was queued: only the in-flight update finishes.
    repeat (50) cyc();
    pulse(4'b0001);
    wait_idle(200);
    model_step();
    repeat (150) cyc();
    check("paused gen", gen_count, m_gen);
    check("paused busy", busy, 0);
    check_grid("paused grid");

    // Reset in the middle of an update.
    pulse(4'b0010);
    repeat (40) cyc();
    check("mid update busy", busy, 1);
    reset_n  = 1'b0;
    video_on = 1'b1;
    x        = 10'd0;
    y        = 10'd0;
    repeat (3) cyc();
    check("mid reset rgb", {r, g, b}, 0);
    check("mid reset busy", busy, 0);
    check("mid reset gen", gen_count, 0);
    reset_n = 1'b1;
    blank();
    cyc();
    m_grid = '0;
    m_gen  = 16'd0;
    check_grid("grid after reset");
    m_lfsr = SEED;
    press(4'b1000, 3000, bc);
    check("post reset seed busy", bc, N);
    model_seed();
    check("post reset seed gen", gen_count, 0);
    check_grid("post reset seed grid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
